// File: rtl/axis_upsize_32_512.sv
// axis_upsize_32_512: packs 32-bit AXI4-Stream beats little-endian into 512-bit beats, tlast closes a word early
module axis_upsize_32_512 (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [31:0]  s_axis_tdata,
  input  logic [3:0]   s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [511:0] m_axis_tdata,
  output logic [63:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready
);
  localparam int S_BITS = 32;
  localparam int M_BITS = 512;
  logic [3:0]          cnt;
  logic [M_BITS-1:0]   acc_data, merged_data;
  logic [M_BITS/8-1:0] acc_keep, merged_keep;
  logic                take, close;
  assign s_axis_tready = aresetn && (!m_axis_tvalid || m_axis_tready);
  assign take  = s_axis_tvalid && s_axis_tready;
  assign close = take && (cnt == 4'd15 || s_axis_tlast);
  // accumulator with the current beat dropped into lane cnt; lanes above cnt are already zero
  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    merged_data[{cnt, 5'd0} +: S_BITS] = s_axis_tdata;
    merged_keep[{cnt, 2'd0} +: S_BITS/8] = s_axis_tkeep;
  end
  // lane counter and accumulator, cleared whenever a word closes
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (take) begin
      cnt      <= close ? 4'd0 : cnt + 4'd1;
      acc_data <= close ? '0 : merged_data;
      acc_keep <= close ? '0 : merged_keep;
    end
  // output holding register: a close overwrites it (even while draining), otherwise a drain empties it
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (close) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= merged_data;
      m_axis_tkeep  <= merged_keep;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_axis_upsize_32_512.sv
// tb_axis_upsize_32_512: directed self-checking bench for the 32->512 AXI4-Stream upsizer
module tb_axis_upsize_32_512;
  logic         aclk = 1'b0;
  logic         aresetn;
  logic [31:0]  s_tdata = '0;
  logic [3:0]   s_tkeep = '0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic [511:0] e;
  int compared = 0;
  int mismatched = 0;

  always #5 aclk = ~aclk;

  axis_upsize_32_512 dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    chk("s_tready_at_beat", s_tready, 1);
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_m_tlast", m_tlast, 0);
    step();
    step();
    aresetn = 1'b1;
    #1;
    chk("post_rst_s_tready", s_tready, 1);
    chk("post_rst_m_tvalid", m_tvalid, 0);

    // full word: lane k = k
    for (int k = 0; k < 16; k++) begin
      beat(k, 4'hF, k == 15);
      if (k == 14) chk("full_no_early_valid", m_tvalid, 0);
    end
    e = '0;
    for (int k = 0; k < 16; k++) e[32*k +: 32] = k;
    chk("full_tvalid", m_tvalid, 1);
    chk("full_tdata", m_tdata, e);
    chk("full_tkeep", m_tkeep, {64{1'b1}});
    chk("full_tlast", m_tlast, 1);
    step();
    chk("full_drained", m_tvalid, 0);

    // short packet
    beat(32'hA, 4'hF, 0);
    beat(32'hB, 4'hF, 0);
    beat(32'hC, 4'h3, 1);
    chk("short_tvalid", m_tvalid, 1);
    chk("short_tdata", m_tdata, 512'h0000000C_0000000B_0000000A);
    chk("short_tkeep", m_tkeep, 64'h3FF);
    chk("short_tlast", m_tlast, 1);
    step();

    // multi-word packet: 20 beats, 0x100+k
    for (int k = 0; k < 16; k++) beat(32'h100 + k, 4'hF, 0);
    e = '0;
    for (int k = 0; k < 16; k++) e[32*k +: 32] = 32'h100 + k;
    chk("multi_w1_tvalid", m_tvalid, 1);
    chk("multi_w1_tdata", m_tdata, e);
    chk("multi_w1_tkeep", m_tkeep, {64{1'b1}});
    chk("multi_w1_tlast", m_tlast, 0);
    for (int k = 16; k < 20; k++) begin
      beat(32'h100 + k, 4'hF, k == 19);
      if (k == 16) chk("multi_w1_drained", m_tvalid, 0);
    end
    chk("multi_w2_tvalid", m_tvalid, 1);
    chk("multi_w2_tdata", m_tdata, 512'h00000113_00000112_00000111_00000110);
    chk("multi_w2_tkeep", m_tkeep, 64'hFFFF);
    chk("multi_w2_tlast", m_tlast, 1);
    step();

    // backpressure
    m_tready = 1'b0;
    beat(32'h300, 4'hF, 0);
    beat(32'h301, 4'hF, 1);
    s_tvalid = 1'b1;
    s_tdata  = 32'h400;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_s_tready_low", s_tready, 0);
      chk("bp_m_tvalid", m_tvalid, 1);
      chk("bp_m_tdata_stable", m_tdata, 512'h00000301_00000300);
      step();
    end
    m_tready = 1'b1;
    #1;
    chk("bp_release_s_tready", s_tready, 1);
    chk("bp_release_m_tlast", m_tlast, 1);
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("bp_next_tvalid", m_tvalid, 1);
    chk("bp_next_tdata", m_tdata, 512'h400);
    chk("bp_next_tkeep", m_tkeep, 64'hF);
    step();
    chk("bp_no_dup", m_tvalid, 0);

    // back-to-back single-beat packets
    for (int k = 0; k < 4; k++) begin
      beat(32'h500 + k, 4'hF, 1);
      chk("single_tvalid", m_tvalid, 1);
      chk("single_tdata", m_tdata, 512'h500 + k);
      chk("single_tkeep", m_tkeep, 64'hF);
      chk("single_tlast", m_tlast, 1);
    end

    // reset mid-packet
    for (int k = 0; k < 7; k++) beat(32'h600 + k, 4'hF, 0);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_m_tdata", m_tdata, 0);
    chk("mid_rst_m_tkeep", m_tkeep, 0);
    chk("mid_rst_s_tready", s_tready, 0);
    step();
    aresetn = 1'b1;
    #1;
    chk("mid_rst_release_s_tready", s_tready, 1);
    chk("mid_rst_release_m_tvalid", m_tvalid, 0);
    beat(32'h700, 4'hF, 0);
    beat(32'h701, 4'hF, 1);
    chk("after_rst_tvalid", m_tvalid, 1);
    chk("after_rst_tdata", m_tdata, 512'h00000701_00000700);
    chk("after_rst_tkeep", m_tkeep, 64'hFF);
    chk("after_rst_tlast", m_tlast, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axis_upsize_32_512.md
# axis_upsize_32_512

Collects 32-bit AXI4-Stream beats into 512-bit beats. It sits at the receive end of a 32-bit stream, such as a 32-bit register-sliced control/data path, and feeds the 512-bit datapath. Packing is little-endian: the first beat lands in the lowest lane. A `tlast` beat closes the current wide word early, and the closed word is emitted from a single output holding register.

## Interface
- `S_BITS`, default 32: input data width. Fixed at 32 and not overridable.
- `M_BITS`, default 512: output data width. `M_BITS/S_BITS` = 16 lanes.
- `aclk` in, 1: the only clock.
- `aresetn` in, 1: reset, asynchronous assert, active-low.
- `s_axis` AXI4S.s, 32-bit `tdata`/4-bit `tkeep`/`tlast`/`tvalid`/`tready`: narrow input.
- `m_axis` AXI4S.m, 512-bit `tdata`/64-bit `tkeep`/`tlast`/`tvalid`/`tready`: wide output.

## Operation
- State:
  - lane counter `cnt[3:0]`
  - accumulator `acc_data[511:0]`, `acc_keep[63:0]`
  - output register `o_valid`, `o_data`, `o_keep`, `o_last`
- Input handshake: `s_axis.tready = aresetn && (!o_valid || m_axis.tready)`. It never depends on `s_axis.tvalid`.
- Accepted beat (`s_tvalid && s_tready`):
  - Writes `tdata` into `acc_data[32*cnt +: 32]` and `tkeep` into `acc_keep[4*cnt +: 4]`.
- Close condition: an accepted beat with `cnt == 15` or `s_axis.tlast == 1`. On close:
  - Load the output register with the accumulator merged with the current beat.
  - Set `o_last = s_axis.tlast`; a full word without `tlast` gives `o_last = 0`.
  - Lanes above `cnt` carry data 0 and keep 0.
  - Reset `cnt` to 0, and clear `acc_data`/`acc_keep` to 0.
- Non-closing accepted beat: `cnt <= cnt + 1`. The output register is untouched.
- Output drain: when `o_valid && m_tready` and no close occurs in the same cycle, `o_valid <= 0`. When a close and a drain occur in the same cycle, the new word replaces the old one and `o_valid` stays 1.
- `tkeep` is passed through per lane without compaction. Sparse `tkeep` values (for example `4'b0000` mid-packet) are stored as given.
- `tlast` on the first beat (`cnt == 0`) emits a word containing only lane 0.
- Wrap-around: after the 16th beat, `cnt` returns to 0 and packing continues in the next word with no bubble.
- Reset, async, at any time:
  - `cnt = 0`, `acc_*` = 0.
  - `m_axis.tvalid = 0`, `tdata = 0`, `tkeep = 0`, `tlast = 0`.
  - `s_axis.tready = 0` while `aresetn` is low.
  - A partially accumulated word is discarded and never emitted.

## Timing
- Latency: `m_axis.tvalid` rises in the cycle after the closing beat is accepted (1 cycle).
- Input throughput: one beat per cycle while the output register is free or draining.
- Output throughput: one wide word per 16 input cycles for full words, and one word per cycle for a stream of `tlast` on every beat.
- Backpressure:
  - While `o_valid && !m_tready`, `s_tready = 0`, including for non-closing beats. This is a deliberate simplification.
  - `m_axis` outputs are held stable until accepted.
- `s_tready` is combinational from `m_axis.tready` and `o_valid`. No combinational path exists from `s_tvalid` to `s_tready`.
- First cycle after `aresetn` deasserts: `s_tready = 1`, `m_tvalid = 0`.

## Test plan
- **Full word:** send 16 beats with `tdata` = `0x00000000`..`0x0000000F`, `tkeep = 0xF`, `tlast` on beat 16, `m_tready = 1` -> one output word with lane k = k, `tkeep` = all ones (64 bits), `tlast = 1`, `tvalid` in the cycle after beat 16.
- **Short packet:** send 3 beats `0xA`, `0xB`, `0xC` with `tlast` on the 3rd, and last `tkeep = 0x3` -> `tdata[95:0] = {0xC, 0xB, 0xA}`, upper bits 0, `tkeep = 64'h0000_0000_0000_03FF`, `tlast = 1`.
- **Multi-word packet:** 20 beats with `tlast` on beat 20 -> word 1 has 16 lanes and `tlast = 0`. Word 2 has 4 lanes, `tkeep = 64'hFFFF`, `tlast = 1`. No input bubble between beat 16 and beat 17.
- **Backpressure:** hold `m_tready = 0` after word 1 closes -> `s_tready = 0` and `m_tdata` stable for 10 cycles. Releasing `m_tready` -> `s_tready` returns to 1 the same cycle, and no beat is lost or duplicated.
- **Back-to-back single-beat packets:** `tlast` on every beat with `m_tready = 1` -> one output word per cycle, each with `tkeep = 64'hF`.
- **Reset mid-packet:** assert `aresetn` low after 7 beats -> outputs are 0 immediately. After release, a new 2-beat packet emits only its own 2 lanes with `tkeep = 64'hFF`, with no residue from the aborted packet.
